// File: rtl/divsqrt_result_buffer.sv
// Credit-gated issue/return buffer for a divSqrt unit whose result side is a
// one-cycle valid pulse with no backpressure. Space for every result is
// reserved at issue time, so a legal return can always be captured.
module divsqrt_result_buffer #(
  parameter int unsigned ExpWidth = 11,
  parameter int unsigned SigWidth = 53,
  parameter int unsigned Depth    = 4,
  localparam int unsigned FormatWidth = ExpWidth + SigWidth,
  localparam int unsigned CntWidth    = $clog2(Depth + 1)
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  // Upstream request
  input  logic                   req_valid_i,
  output logic                   req_ready_o,
  // Unit issue side
  output logic                   unit_in_valid_o,
  input  logic                   unit_in_ready_i,
  // Unit result side
  input  logic                   unit_out_valid_i,
  input  logic                   unit_sqrt_op_i,
  input  logic [FormatWidth-1:0] unit_out_i,
  input  logic [4:0]             unit_flags_i,
  // Downstream result
  output logic                   res_valid_o,
  input  logic                   res_ready_i,
  output logic                   res_sqrt_op_o,
  output logic [FormatWidth-1:0] res_out_o,
  output logic [4:0]             res_flags_o,
  // Status
  output logic [CntWidth-1:0]    occupancy_o,
  output logic [CntWidth-1:0]    inflight_o,
  output logic                   protocol_error_o
);

  localparam int unsigned PtrWidth   = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned EntryWidth = FormatWidth + 6;
  localparam logic [CntWidth-1:0] CntDepth = CntWidth'(Depth);
  localparam logic [CntWidth:0]   SumDepth = (CntWidth + 1)'(Depth);
  localparam logic [PtrWidth-1:0] PtrLast  = PtrWidth'(Depth - 1);

  logic [CntWidth-1:0]   inflight_q, inflight_d;
  logic [CntWidth-1:0]   occupancy_q, occupancy_d;
  logic [PtrWidth-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PtrWidth-1:0]   rd_ptr_q, rd_ptr_d;
  logic                  protocol_error_q, protocol_error_d;
  logic [EntryWidth-1:0] mem_q [Depth];

  logic                  credit;
  logic                  issue;
  logic                  accept;
  logic                  pop;
  logic [CntWidth:0]     reserved;
  logic [EntryWidth-1:0] head;

  // Issue/return/pop decode from registered counters only.
  always_comb begin
    reserved        = {1'b0, inflight_q} + {1'b0, occupancy_q};
    credit          = reserved < SumDepth;
    unit_in_valid_o = req_valid_i & credit;
    req_ready_o     = unit_in_ready_i & credit;
    issue           = req_valid_i & unit_in_ready_i & credit;
    accept          = unit_out_valid_i & (inflight_q != '0) & (occupancy_q != CntDepth);
    res_valid_o     = occupancy_q != '0;
    pop             = res_valid_o & res_ready_i;
  end

  // Next-state for counters, pointers and the sticky error flag.
  always_comb begin
    inflight_d       = inflight_q;
    occupancy_d      = occupancy_q;
    wr_ptr_d         = wr_ptr_q;
    rd_ptr_d         = rd_ptr_q;
    protocol_error_d = protocol_error_q;

    unique case ({issue, accept})
      2'b10:   inflight_d = inflight_q + CntWidth'(1);
      2'b01:   inflight_d = inflight_q - CntWidth'(1);
      default: inflight_d = inflight_q;
    endcase

    unique case ({accept, pop})
      2'b10:   occupancy_d = occupancy_q + CntWidth'(1);
      2'b01:   occupancy_d = occupancy_q - CntWidth'(1);
      default: occupancy_d = occupancy_q;
    endcase

    if (accept) begin
      wr_ptr_d = (wr_ptr_q == PtrLast) ? '0 : wr_ptr_q + PtrWidth'(1);
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PtrLast) ? '0 : rd_ptr_q + PtrWidth'(1);
    end

    // A return with nothing in flight, or with no room, is dropped and flagged.
    if (unit_out_valid_i && !accept) begin
      protocol_error_d = 1'b1;
    end
  end

  // Control state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      inflight_q       <= '0;
      occupancy_q      <= '0;
      wr_ptr_q         <= '0;
      rd_ptr_q         <= '0;
      protocol_error_q <= 1'b0;
    end else begin
      inflight_q       <= inflight_d;
      occupancy_q      <= occupancy_d;
      wr_ptr_q         <= wr_ptr_d;
      rd_ptr_q         <= rd_ptr_d;
      protocol_error_q <= protocol_error_d;
    end
  end

  // Result storage; not reset since res_* are masked while empty.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      mem_q[wr_ptr_q] <= {unit_sqrt_op_i, unit_flags_i, unit_out_i};
    end
  end

  // Head entry presented downstream, zeroed while empty.
  always_comb begin
    head          = res_valid_o ? mem_q[rd_ptr_q] : '0;
    res_sqrt_op_o = head[EntryWidth-1];
    res_flags_o   = head[EntryWidth-2 -: 5];
    res_out_o     = head[FormatWidth-1:0];
    occupancy_o      = occupancy_q;
    inflight_o       = inflight_q;
    protocol_error_o = protocol_error_q;
  end

endmodule
